// File: rtl/full_xor_pkg.sv
// full_xor_pkg: share-count limits and refresh-schedule helpers for full_xor_unmask
// Contents: MAX_SHARES, f_npairs (pairs in one layer), f_rnd_base (first word of a layer),
//           f_rnd_idx (random word used by the pair whose lower member is share i),
//           f_randnum (random words consumed per beat).
package full_xor_pkg;

    localparam int MAX_SHARES = 16;

    // Share i pairs with i+s when i/s is even and the partner exists.
    function automatic int f_npairs(input int n, input int layer);
        int s;
        int c;
        s = 1 << layer;
        c = 0;
        for (int i = 0; i < MAX_SHARES; i++)
            if (i < n && ((i / s) % 2 == 0) && (i + s < n))
                c++;
        return c;
    endfunction

    function automatic int f_rnd_base(input int n, input int layer);
        int b;
        b = 0;
        for (int l = 0; l < layer; l++)
            b += f_npairs(n, l);
        return b;
    endfunction

    // Within a layer the pairs are numbered in ascending i: s pairs per 2s-wide block.
    function automatic int f_rnd_idx(input int n, input int layer, input int i);
        int s;
        s = 1 << layer;
        return f_rnd_base(n, layer) + (i / (2 * s)) * s + (i % s);
    endfunction

    function automatic int f_randnum(input int n);
        return f_rnd_base(n, $clog2(n));
    endfunction

endpackage

// File: rtl/lix_reg.sv
// lix_reg: enabled register with synchronous active-low reset and synchronous clear
// Ports: clk_i clock; rst_ni reset (priority); clr_i zeroize; en_i load enable; d_i/q_o data.
module lix_reg #(
    parameter int W = 1
)(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            q_o <= '0;
        else if (clr_i)
            q_o <= '0;
        else if (en_i)
            q_o <= d_i;
    end
endmodule

// File: rtl/lix_xor.sv
// lix_xor: bitwise XOR of two words
// Ports: a_i, b_i operands; y_o result.
module lix_xor #(
    parameter int W = 1
)(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);
    assign y_o = a_i ^ b_i;
endmodule

// File: rtl/xor_refresh_layer.sv
// xor_refresh_layer: one combinational pairwise refresh layer with stride 2^LAYER
// Ports: x_i shares in; rnd_i this layer's random words (pair order); x_o refreshed shares.
module xor_refresh_layer
    import full_xor_pkg::*;
#(
    parameter int  K_WIDTH  = 32,
    parameter int  N_SHARES = 5,
    parameter int  LAYER    = 0,
    localparam int NPAIRS   = f_npairs(N_SHARES, LAYER)
)(
    input  logic [K_WIDTH*N_SHARES-1:0] x_i,
    input  logic [K_WIDTH*NPAIRS-1:0]   rnd_i,
    output logic [K_WIDTH*N_SHARES-1:0] x_o
);
    localparam int S = 1 << LAYER;

    genvar i;
    for (i = 0; i < N_SHARES; i++) begin : g_sh
        // Both members of a pair use the word indexed by the lower member.
        localparam int P = ((i / S) % 2 == 0) ? i : i - S;
        localparam int W = f_rnd_idx(N_SHARES, LAYER, P) - f_rnd_idx(N_SHARES, LAYER, 0);
        if (P + S < N_SHARES) begin : g_pair
            lix_xor #(.W(K_WIDTH)) u_xor (
                .a_i(x_i[i*K_WIDTH +: K_WIDTH]),
                .b_i(rnd_i[W*K_WIDTH +: K_WIDTH]),
                .y_o(x_o[i*K_WIDTH +: K_WIDTH])
            );
        end else begin : g_pass
            assign x_o[i*K_WIDTH +: K_WIDTH] = x_i[i*K_WIDTH +: K_WIDTH];
        end
    end
endmodule

// File: rtl/full_xor_unmask.sv
// full_xor_unmask: pipelined refresh-then-XOR recombiner for Boolean-masked shares
// Ports: clk; rst_n sync active-low reset; ena clock enable; clr zeroize (with ena);
//        i_valid/i_ready/i_x/rnd input beat; o_valid/o_ready/o_z unmasked output.
module full_xor_unmask
    import full_xor_pkg::*;
#(
    parameter int  K_WIDTH    = 32,
    parameter int  N_SHARES   = 5,
    parameter int  REG_LAYERS = 1,
    localparam int LAYERS     = $clog2(N_SHARES),
    localparam int RANDNUM    = f_randnum(N_SHARES)
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        clr,
    input  logic                        i_valid,
    output logic                        i_ready,
    input  logic [K_WIDTH*N_SHARES-1:0] i_x,
    input  logic [K_WIDTH*RANDNUM-1:0]  rnd,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [K_WIDTH-1:0]          o_z
);
    localparam int KN = K_WIDTH * N_SHARES;

    logic              adv;
    logic              wipe;
    logic [KN-1:0]     x_last;
    logic              v_last;
    logic [K_WIDTH-1:0] z_d;

    assign adv     = ena & (~o_valid | o_ready);
    assign wipe    = ena & clr;
    assign i_ready = adv;

    genvar l;
    for (l = 0; l < LAYERS; l++) begin : g_l
        localparam int NP     = f_npairs(N_SHARES, l);
        localparam int RIN    = RANDNUM - f_rnd_idx(N_SHARES, l, 0);
        localparam bit IS_REG = (REG_LAYERS != 0) || (l == LAYERS - 1);
        logic [KN-1:0]          x_in;
        logic [KN-1:0]          x_mix;
        logic [KN-1:0]          x_q;
        logic [K_WIDTH*RIN-1:0] r_in;
        logic                   v_in;
        logic                   v_q;
        if (l == 0) begin : g_src
            assign x_in = i_x;
            assign r_in = rnd;
            assign v_in = i_valid;
        end else begin : g_src
            assign x_in = g_l[l-1].x_q;
            assign r_in = g_l[l-1].g_r.r_q;
            assign v_in = g_l[l-1].v_q;
        end
        // Each layer consumes the low words of the randomness it receives.
        xor_refresh_layer #(.K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES), .LAYER(l)) u_layer (
            .x_i(x_in),
            .rnd_i(r_in[K_WIDTH*NP-1:0]),
            .x_o(x_mix)
        );
        // Words for later layers travel with the beat so every layer uses its own beat's randomness.
        if (l < LAYERS - 1) begin : g_r
            logic [K_WIDTH*(RIN-NP)-1:0] r_q;
            if (IS_REG) begin : g_st
                lix_reg #(.W(K_WIDTH*(RIN-NP))) u_r (
                    .clk_i(clk), .rst_ni(rst_n), .clr_i(wipe), .en_i(adv),
                    .d_i(r_in[K_WIDTH*RIN-1:K_WIDTH*NP]), .q_o(r_q)
                );
            end else begin : g_wire
                assign r_q = r_in[K_WIDTH*RIN-1:K_WIDTH*NP];
            end
        end
        if (IS_REG) begin : g_st
            lix_reg #(.W(KN)) u_x (
                .clk_i(clk), .rst_ni(rst_n), .clr_i(wipe), .en_i(adv), .d_i(x_mix), .q_o(x_q)
            );
            lix_reg #(.W(1)) u_v (
                .clk_i(clk), .rst_ni(rst_n), .clr_i(wipe), .en_i(adv), .d_i(v_in), .q_o(v_q)
            );
        end else begin : g_wire
            assign x_q = x_mix;
            assign v_q = v_in;
        end
    end

    assign x_last = g_l[LAYERS-1].x_q;
    assign v_last = g_l[LAYERS-1].v_q;

    always_comb begin
        z_d = '0;
        for (int j = 0; j < N_SHARES; j++)
            z_d = z_d ^ x_last[j*K_WIDTH +: K_WIDTH];
    end

    // o_z only loads real beats so bubbles leave the last result in place.
    lix_reg #(.W(K_WIDTH)) u_z (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(wipe), .en_i(adv & v_last), .d_i(z_d), .q_o(o_z)
    );
    lix_reg #(.W(1)) u_ov (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(wipe), .en_i(adv), .d_i(v_last), .q_o(o_valid)
    );
endmodule
